prog_updown_counter: RTL and testbench

//  Parametrised modulo-N up/down counter with built-in clock-enable prescaler,

---
 rtl/prog_updown_counter.sv | 93 +++++++++
 tb/tb_prog_updown_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/prog_updown_counter.sv
// Modulo-N up/down counter with clock-enable prescaler, parallel load and terminal-count pulse.
// Optional build macro: PUC_SATURATE_EN (hold at the bounds instead of wrapping).
module prog_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 4
) (
    input  logic             puc_clk,
    input  logic             puc_rst,
    input  logic             puc_en,
    input  logic             puc_dir,
    input  logic             puc_load,
    input  logic [WIDTH-1:0] puc_load_val,
    output logic [WIDTH-1:0] puc_q,
    output logic             puc_tick,
    output logic             puc_tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0] MOD_LAST = (WIDTH + 1)'(MODULUS - 1);

    logic [PW-1:0]    r_ps;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_tc;

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_load_ext;
    logic [WIDTH:0] w_load_q;
    logic [WIDTH:0] w_up;
    logic [WIDTH:0] w_dn;
    logic [WIDTH:0] w_step_q;
    logic [WIDTH:0] w_next;
    logic           w_at_top;
    logic           w_at_bot;
    logic           w_bound;
    logic           w_step;
    logic           w_unused_msb;

    // One spare bit keeps +1 at MODULUS == 2**WIDTH from overflowing
    always_comb begin
        w_q_ext    = {1'b0, r_q};
        w_load_ext = {1'b0, puc_load_val};
        w_load_q   = (w_load_ext > MOD_LAST) ? MOD_LAST : w_load_ext;
        w_at_top   = (w_q_ext == MOD_LAST);
        w_at_bot   = (r_q == '0);
        w_bound    = puc_dir ? w_at_top : w_at_bot;
        w_up       = w_q_ext + 1'b1;
        w_dn       = w_q_ext - 1'b1;
`ifdef PUC_SATURATE_EN
        w_step_q   = w_bound ? w_q_ext : (puc_dir ? w_up : w_dn);
`else
        if (puc_dir)
            w_step_q = w_at_top ? '0 : w_up;
        else
            w_step_q = w_at_bot ? MOD_LAST : w_dn;
`endif
        w_step     = puc_en && (r_ps == PS_LAST);
        w_next     = puc_load ? w_load_q : w_step_q;
    end

    assign w_unused_msb = w_next[WIDTH];

    always_ff @(posedge puc_clk or negedge puc_rst) begin
        if (!puc_rst) begin
            r_ps   <= '0;
            r_q    <= '0;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (puc_load) begin
            r_ps   <= '0;
            r_q    <= w_next[WIDTH-1:0];
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end else if (w_step) begin
            r_ps   <= '0;
            r_q    <= w_next[WIDTH-1:0];
            r_tick <= 1'b1;
            r_tc   <= w_bound;
        end else begin
            if (puc_en)
                r_ps <= r_ps + 1'b1;
            r_tick <= 1'b0;
            r_tc   <= 1'b0;
        end
    end

    assign puc_q    = r_q;
    assign puc_tick = r_tick;
    assign puc_tc   = r_tc;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Randomized bench: three counter configurations share one stimulus stream
// and are checked against an arithmetic reference model.
module tb_prog_updown_counter;

    localparam int N = 3;
    localparam int P[N] = '{1, 4, 3};
    localparam int M[N] = '{10, 10, 16};

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] q[N];
    logic       tick[N];
    logic       tc[N];

    int mq[N];
    int mph[N];
    int mtick[N];
    int mtc[N];

    int n_chk;
    int n_err;

    prog_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_p1 (
        .puc_clk(clk), .puc_rst(rst_n), .puc_en(en), .puc_dir(dir),
        .puc_load(ld), .puc_load_val(lv),
        .puc_q(q[0]), .puc_tick(tick[0]), .puc_tc(tc[0])
    );

    prog_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u_p4 (
        .puc_clk(clk), .puc_rst(rst_n), .puc_en(en), .puc_dir(dir),
        .puc_load(ld), .puc_load_val(lv),
        .puc_q(q[1]), .puc_tick(tick[1]), .puc_tc(tc[1])
    );

    prog_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_m16 (
        .puc_clk(clk), .puc_rst(rst_n), .puc_en(en), .puc_dir(dir),
        .puc_load(ld), .puc_load_val(lv),
        .puc_q(q[2]), .puc_tick(tick[2]), .puc_tc(tc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k]    = 0;
            mph[k]   = 0;
            mtick[k] = 0;
            mtc[k]   = 0;
        end
    endtask

    // Behaviour at one rising edge, from the counting rules
    task automatic model_edge(input bit e, input bit d, input bit l,
                              input int v);
        int tgt;
        for (int k = 0; k < N; k++) begin
            mtick[k] = 0;
            mtc[k]   = 0;
            if (l) begin
                mq[k]  = (v > M[k] - 1) ? M[k] - 1 : v;
                mph[k] = 0;
            end else if (e) begin
                mph[k] = (mph[k] + 1) % P[k];
                if (mph[k] == 0) begin
                    mtick[k] = 1;
                    tgt = d ? mq[k] + 1 : mq[k] - 1;
                    if (tgt < 0 || tgt >= M[k]) begin
                        mtc[k] = 1;
`ifndef PUC_SATURATE_EN
                        mq[k] = (tgt + M[k]) % M[k];
`endif
                    end else begin
                        mq[k] = tgt;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_q%0d", tag, k), 32'(q[k]), 32'(mq[k]));
            chk($sformatf("%s_tick%0d", tag, k), 32'(tick[k]), 32'(mtick[k]));
            chk($sformatf("%s_tc%0d", tag, k), 32'(tc[k]), 32'(mtc[k]));
        end
    endtask

    // Called away from the rising edge; returns at the falling edge
    task automatic cycle(input string tag, input bit e, input bit d,
                         input bit l, input int v);
        en  = e;
        dir = d;
        ld  = l;
        lv  = 4'(v);
        @(posedge clk);
        model_edge(e, d, l, v);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Asynchronous assert between edges, release on a falling edge
    task automatic mid_reset(input string tag);
        @(posedge clk);
        model_edge(en, dir, ld, int'(lv));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit d;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        dir   = 1'b1;
        ld    = 1'b0;
        lv    = '0;
        model_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) cycle("up", 1, 1, 0, 0);
        cycle("ld7", 0, 1, 1, 7);
        for (int i = 0; i < 3; i++) cycle("run", 1, 1, 0, 0);
        mid_reset("arst");
        for (int i = 0; i < 6; i++) cycle("down", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("hold", 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle("resume", 1, 1, 0, 0);
        cycle("ld12", 1, 1, 1, 12);
        cycle("ld15", 0, 0, 1, 15);
        cycle("ld0", 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle("pre", 1, 1, 0, 0);
        cycle("ldtick", 1, 1, 1, 5);
        for (int i = 0; i < 5; i++) cycle("post", 1, 1, 0, 0);
        cycle("ld8", 1, 1, 1, 8);
        for (int i = 0; i < 4; i++) cycle("top", 1, 1, 0, 0);
        cycle("topdn", 1, 0, 0, 0);

        d = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                mid_reset("rarst");
            end else begin
                if ($urandom_range(9) == 0) d = ~d;
                cycle("rnd", $urandom_range(7) != 0, d,
                      $urandom_range(19) == 0, int'($urandom_range(15)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
